usb3_descramble: RTL
====================

# usb3_descramble

RX-path counterpart of the TX scrambler/SKP padder, sitting between the PIPE RX word interface (after elastic buffer) and the link-layer receive logic. It removes SKP ordered sets inserted by the far end, descrambles data symbols with the USB 3.0 LFSR keystream, and repacks the remaining halfwords into dense 32-bit words. On each COM it resynchronises the LFSR.

## Interface
- No parameters.
- local_clk  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on local_clk.
- enable  in  1  1 = descramble + SKP removal; 0 = passthrough, keystream not advanced.
- in_data  in  32  received symbols; lanes [7:0] earliest in time, [31:24] latest.
- in_datak  in  4  per-lane K flag.
- in_valid  in  1  word present this cycle; gaps allowed.
- out_data  out  32  descrambled, SKP-free word; [15:0] earlier halfword.
- out_datak  out  4  K flags aligned to out_data.
- out_valid  out  1  out_data/out_datak valid this cycle.
- skp_seen  out  1  one-cycle pulse per input word containing ≥1 aligned SKP halfword.
- err_skp_misalign  out  1  one-cycle pulse: a halfword held exactly one SKP.
- err_realign  out  1  one-cycle pulse: COM arrived while a holdover halfword was pending.

## Operation
- SKP = byte 0x3C with K flag set. SKP is legal only as a full halfword (lanes 1:0 or 3:2, both SKP).
- Halfword classes per input word: low = lanes 1:0, high = lanes 3:2; a halfword is "data" unless it is a full SKP pair. Half-SKP halfword: treated as data, err_skp_misalign pulses.
- COM = 0xBC with K in lane 0 only. COM in lanes 1–3 is data, no resync.
- Keystream: instance of the codebase usb3_lfsr, data_in 0, scram_init 16'h7DBD, scram_rst = (COM & in_valid & enable) | ~reset_n, scram_en = pool refill or COM. Keystream word = byte-reversed data_out.
- Keystream pool: 64-bit shift pool in halfword units, depth 0–4. Each data halfword (low first, then high) consumes the next pool halfword, whether or not its lanes are K; SKP halfwords consume nothing. Refill 32 bits whenever depth after consumption ≤ 2. Pool must supply 2 halfwords every cycle back-to-back; prefetch on reset and COM so no underflow is possible.
- Descramble: per lane, D byte XOR keystream byte; K byte passed unchanged. COM word itself is not descrambled; pool flushed and LFSR reset so the word after COM uses the first post-seed keystream.
- Repack, with holdover register H (one halfword + valid):
  - no H, 2 data halfwords: emit {hi, lo}.
  - no H, 1: store in H.
  - H, 2: emit {first, H}, store second in H.
  - H, 1: emit {d, H}, clear H.
  - 0 data halfwords: no output, H unchanged.
- COM word with H valid: H dropped, err_realign pulses, COM word processed as no-H.
- enable=0: input registered straight through (same 3-cycle latency), H cleared, pool/LFSR frozen, no error pulses.
- in_valid=0: no state change except pipeline advance; out_valid 0 for the corresponding slot.

## Timing
- 3-stage pipeline: register input (S1), classify + descramble (S2), repack/output (S3).
- out_valid rises 3 cycles after the in_valid word that completes an output word.
- skp_seen and err_skp_misalign pulse 2 cycles after the offending word (S2). err_realign pulses at S3 with the COM word.
- Reset values: out_data 0, out_datak 0, out_valid 0, skp_seen 0, err_skp_misalign 0, err_realign 0, H invalid, pool depth 0.
- Reset mid-stream: all in-flight words discarded; first valid output ≥3 cycles after reset_n high.
- Simultaneous COM and refill: COM wins; pool refilled from reset LFSR.

## Test plan
- Reset, enable=0, in_data 0x12345678 / k 0000 for 1 cycle -> out_data 0x12345678, k 0000, out_valid exactly 3 cycles later; no pulses.
- enable=1, word 0x4A4A4ABC k 0001, then 4 words equal to the post-COM keystream (scrambled zeros) -> COM word passed unchanged, then four outputs of 0x00000000 k 0000.
- After COM: 0x3C3C_xxxx k 1100, then two scrambled words -> skp_seen pulse; outputs {lo(w2), lo(w1)} then {lo(w3), hi(w2)}, all descrambling to 0; H holds hi(w3).
- Word 0x3C3C3C3C k 1111 mid-stream -> no output, pool depth unchanged, next data still decodes to 0.
- Word 0x00003CAA k 0010 -> err_skp_misalign pulse; halfword treated as data and descrambled.
- H pending, then COM word -> err_realign pulse; subsequent scrambled zeros decode to 0x00000000.

Source files
------------

// File: rtl/usb3_descramble.sv
// USB 3.0 receive-side descrambler with SKP removal and halfword repacking.
// Sits between the PIPE RX word stream (post elastic buffer) and link-layer
// receive logic. Also contains the keystream generator it uses.

// Keystream generator: x^16 + x^5 + x^4 + x^3 + 1, 32 bits per step.
// data_out carries the serial keystream MSB-first, so data_out[31:24] holds the
// earliest byte and bit 7 of each byte is the earliest bit of that byte.
module usb3_lfsr (
  input  logic        local_clk,
  input  logic [31:0] data_in,
  input  logic        scram_en,
  input  logic        scram_rst,
  input  logic [15:0] scram_init,
  output logic [31:0] data_out
);

  logic [15:0] r_state;
  logic [15:0] w_next;
  logic [31:0] w_stream;
  logic [15:0] w_walk;

  // Walk the register 32 bit-times ahead to get this step's keystream and next state
  always_comb begin
    w_walk   = r_state;
    w_stream = '0;
    for (int i = 31; i >= 0; i--) begin
      w_stream[i] = w_walk[15];
      w_walk      = {w_walk[14:0], 1'b0} ^ (w_walk[15] ? 16'h0039 : 16'h0000);
    end
    w_next = w_walk;
  end

  // Reseed has priority over advancing
  always_ff @(posedge local_clk) begin
    if (scram_rst) begin
      r_state <= scram_init;
    end else if (scram_en) begin
      r_state <= w_next;
    end
  end

  assign data_out = data_in ^ w_stream;

endmodule

module usb3_descramble (
  input  logic        local_clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_datak,
  input  logic        in_valid,
  output logic [31:0] out_data,
  output logic [3:0]  out_datak,
  output logic        out_valid,
  output logic        skp_seen,
  output logic        err_skp_misalign,
  output logic        err_realign
);

  // A lane byte is an SKP symbol only when it is 0x3C flagged as K
  function automatic logic skpByte(input logic [7:0] b, input logic k);
    return k && (b == 8'h3C);
  endfunction

  // K lanes pass untouched, data lanes are XORed with the keystream
  function automatic logic [15:0] descrambleHalf(input logic [15:0] hw, input logic [1:0] hk,
                                                 input logic [15:0] ks);
    logic [15:0] w_res;
    w_res[7:0]  = hk[0] ? hw[7:0]  : (hw[7:0]  ^ ks[7:0]);
    w_res[15:8] = hk[1] ? hw[15:8] : (hw[15:8] ^ ks[15:8]);
    return w_res;
  endfunction

  // Stage 1 registers
  logic        r_s1Valid;
  logic        r_s1En;
  logic [31:0] r_s1Data;
  logic [3:0]  r_s1K;

  // Stage 2 registers
  logic        r_s2Valid;
  logic        r_s2En;
  logic        r_s2Com;
  logic [1:0]  r_s2Cnt;
  logic [15:0] r_s2Hw0;
  logic [1:0]  r_s2K0;
  logic [15:0] r_s2Hw1;
  logic [1:0]  r_s2K1;

  // Holdover halfword and keystream pool
  logic        r_hValid;
  logic [15:0] r_hData;
  logic [1:0]  r_hK;
  logic [63:0] r_pool;
  logic [2:0]  r_poolDepth;

  // Classification / descramble wires
  logic        w_loSkp;
  logic        w_hiSkp;
  logic        w_loHalf;
  logic        w_hiHalf;
  logic        w_isCom;
  logic        w_loData;
  logic        w_hiData;
  logic [1:0]  w_cnt;
  logic        w_active;
  logic        w_descr;
  logic [15:0] w_firstRaw;
  logic [1:0]  w_firstK;
  logic [15:0] w_first;
  logic [15:0] w_second;

  // Pool / keystream wires
  logic [2:0]  w_consume;
  logic [2:0]  w_remain;
  logic        w_flush;
  logic        w_refill;
  logic        w_scramRst;
  logic        w_scramEn;
  logic [31:0] w_lfsrOut;
  logic [31:0] w_ksWord;
  logic [63:0] w_poolShift;
  logic [63:0] w_poolFill;
  logic        w_hHeld;

  assign w_scramRst = (in_valid & enable & in_datak[0] & (in_data[7:0] == 8'hBC)) | ~reset_n;
  assign w_scramEn  = w_refill | w_flush;
  assign w_ksWord   = {w_lfsrOut[7:0], w_lfsrOut[15:8], w_lfsrOut[23:16], w_lfsrOut[31:24]};

  usb3_lfsr u_lfsr (
    .local_clk  (local_clk),
    .data_in    (32'h0000_0000),
    .scram_en   (w_scramEn),
    .scram_rst  (w_scramRst),
    .scram_init (16'h7DBD),
    .data_out   (w_lfsrOut)
  );

  // Register the raw input word along with the enable it arrived under
  always_ff @(posedge local_clk) begin
    if (!reset_n) begin
      r_s1Valid <= 1'b0;
      r_s1En    <= 1'b0;
      r_s1Data  <= '0;
      r_s1K     <= '0;
    end else begin
      r_s1Valid <= in_valid;
      r_s1En    <= enable;
      r_s1Data  <= in_data;
      r_s1K     <= in_datak;
    end
  end

  assign w_loSkp  = skpByte(r_s1Data[7:0], r_s1K[0]) & skpByte(r_s1Data[15:8], r_s1K[1]);
  assign w_hiSkp  = skpByte(r_s1Data[23:16], r_s1K[2]) & skpByte(r_s1Data[31:24], r_s1K[3]);
  assign w_loHalf = skpByte(r_s1Data[7:0], r_s1K[0]) ^ skpByte(r_s1Data[15:8], r_s1K[1]);
  assign w_hiHalf = skpByte(r_s1Data[23:16], r_s1K[2]) ^ skpByte(r_s1Data[31:24], r_s1K[3]);
  assign w_isCom  = r_s1K[0] & (r_s1Data[7:0] == 8'hBC);
  assign w_loData = ~w_loSkp;
  assign w_hiData = ~w_hiSkp;
  assign w_cnt    = {1'b0, w_loData} + {1'b0, w_hiData};
  assign w_active = r_s1Valid & r_s1En;
  assign w_descr  = r_s1En & ~w_isCom;

  // Compact the data halfwords to the front and descramble them in order
  always_comb begin
    w_firstRaw = r_s1Data[15:0];
    w_firstK   = r_s1K[1:0];
    if (r_s1En && !w_loData) begin
      w_firstRaw = r_s1Data[31:16];
      w_firstK   = r_s1K[3:2];
    end
    w_first  = w_firstRaw;
    w_second = r_s1Data[31:16];
    if (w_descr) begin
      w_first  = descrambleHalf(w_firstRaw, w_firstK, r_pool[15:0]);
      w_second = descrambleHalf(r_s1Data[31:16], r_s1K[3:2], r_pool[31:16]);
    end
  end

  assign w_consume = (w_active && !w_isCom) ? {1'b0, w_cnt} : 3'd0;
  assign w_remain  = r_poolDepth - w_consume;
  assign w_flush   = w_active & w_isCom;
  assign w_refill  = enable & ~w_flush & (w_remain <= 3'd2);

  // Drop consumed halfwords and append a fresh keystream word behind the remainder
  always_comb begin
    case (w_consume)
      3'd0:    w_poolShift = r_pool;
      3'd1:    w_poolShift = {16'h0000, r_pool[63:16]};
      default: w_poolShift = {32'h0000_0000, r_pool[63:32]};
    endcase
    case (w_remain)
      3'd0:    w_poolFill = w_poolShift | {32'h0000_0000, w_ksWord};
      3'd1:    w_poolFill = w_poolShift | {16'h0000, w_ksWord, 16'h0000};
      default: w_poolFill = w_poolShift | {w_ksWord, 32'h0000_0000};
    endcase
  end

  // Keystream pool: COM flushes and reloads from the freshly reseeded generator
  always_ff @(posedge local_clk) begin
    if (!reset_n) begin
      r_pool      <= '0;
      r_poolDepth <= 3'd0;
    end else if (w_flush) begin
      r_pool      <= {32'h0000_0000, w_ksWord};
      r_poolDepth <= 3'd2;
    end else if (w_refill) begin
      r_pool      <= w_poolFill;
      r_poolDepth <= w_remain + 3'd2;
    end else begin
      r_pool      <= w_poolShift;
      r_poolDepth <= w_remain;
    end
  end

  // Capture the classified halfwords and raise the per-word SKP status pulses
  always_ff @(posedge local_clk) begin
    if (!reset_n) begin
      r_s2Valid        <= 1'b0;
      r_s2En           <= 1'b0;
      r_s2Com          <= 1'b0;
      r_s2Cnt          <= 2'd0;
      r_s2Hw0          <= '0;
      r_s2K0           <= '0;
      r_s2Hw1          <= '0;
      r_s2K1           <= '0;
      skp_seen         <= 1'b0;
      err_skp_misalign <= 1'b0;
    end else begin
      r_s2Valid        <= r_s1Valid;
      r_s2En           <= r_s1En;
      r_s2Com          <= w_active & w_isCom;
      r_s2Cnt          <= w_cnt;
      r_s2Hw0          <= w_first;
      r_s2K0           <= w_firstK;
      r_s2Hw1          <= w_second;
      r_s2K1           <= r_s1K[3:2];
      skp_seen         <= w_active & (w_loSkp | w_hiSkp);
      err_skp_misalign <= w_active & (w_loHalf | w_hiHalf);
    end
  end

  assign w_hHeld = r_hValid & ~r_s2Com;

  // Repack data halfwords through the holdover register into dense output words
  always_ff @(posedge local_clk) begin
    if (!reset_n) begin
      out_data    <= '0;
      out_datak   <= '0;
      out_valid   <= 1'b0;
      err_realign <= 1'b0;
      r_hValid    <= 1'b0;
      r_hData     <= '0;
      r_hK        <= '0;
    end else begin
      out_valid   <= 1'b0;
      err_realign <= 1'b0;
      if (r_s2Valid) begin
        if (!r_s2En) begin
          out_data  <= {r_s2Hw1, r_s2Hw0};
          out_datak <= {r_s2K1, r_s2K0};
          out_valid <= 1'b1;
          r_hValid  <= 1'b0;
        end else begin
          err_realign <= r_s2Com & r_hValid;
          case ({w_hHeld, r_s2Cnt})
            3'b0_10: begin
              out_data  <= {r_s2Hw1, r_s2Hw0};
              out_datak <= {r_s2K1, r_s2K0};
              out_valid <= 1'b1;
              r_hValid  <= 1'b0;
            end
            3'b0_01: begin
              r_hData  <= r_s2Hw0;
              r_hK     <= r_s2K0;
              r_hValid <= 1'b1;
            end
            3'b1_10: begin
              out_data  <= {r_s2Hw0, r_hData};
              out_datak <= {r_s2K0, r_hK};
              out_valid <= 1'b1;
              r_hData   <= r_s2Hw1;
              r_hK      <= r_s2K1;
              r_hValid  <= 1'b1;
            end
            3'b1_01: begin
              out_data  <= {r_s2Hw0, r_hData};
              out_datak <= {r_s2K0, r_hK};
              out_valid <= 1'b1;
              r_hValid  <= 1'b0;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

endmodule
